// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: requester handshakes, register-file write port,
// destination-register claims and the pending scoreboard.
interface wb_arbiter_if #(
    parameter int unsigned REQUESTERS = 3,
    parameter int unsigned COUNT      = 32,
    parameter int unsigned DATA_W     = 32
);
    localparam int unsigned IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;

    logic [REQUESTERS-1:0]              req_valid;
    logic [REQUESTERS-1:0]              req_ready;
    logic [REQUESTERS-1:0][IDX_W-1:0]   req_addr;
    logic [REQUESTERS-1:0][DATA_W-1:0]  req_data;
    logic                               wr_en;
    logic [IDX_W-1:0]                   wr_addr;
    logic [DATA_W-1:0]                  wr_data;
    logic                               claim_valid;
    logic [IDX_W-1:0]                   claim_addr;
    logic [COUNT-1:0]                   pending;

    // Requester / issue side
    modport master (
        output req_valid, req_addr, req_data, claim_valid, claim_addr,
        input  req_ready, wr_en, wr_addr, wr_data, pending
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_addr, req_data, claim_valid, claim_addr,
        output req_ready, wr_en, wr_addr, wr_data, pending
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter sharing one register-file write port, with a
// per-register pending scoreboard set by issue-stage claims and cleared by
// writebacks.
module wb_arbiter #(
    parameter int unsigned REQUESTERS = 3,
    parameter int unsigned COUNT      = 32,
    parameter int unsigned DATA_W     = 32
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int unsigned PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    logic [PTR_W-1:0]  last_q;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_any;
    logic [PTR_W:0]    cand;
    logic              transfer;
    logic [IDX_W-1:0]  xfer_addr;
    logic [DATA_W-1:0] xfer_data;
    logic              wr_en_q;
    logic [IDX_W-1:0]  wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [COUNT-1:0]  pending_q;
    logic [COUNT-1:0]  pending_d;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= REQUESTERS; k++) begin
            // One extra bit so the sum cannot overflow before the wrap
            cand = {1'b0, last_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(REQUESTERS)) begin
                cand = cand - (PTR_W+1)'(REQUESTERS);
            end
            if (!grant_any && bus.req_valid[cand[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
    end

    // Grant is suppressed entirely while reset is sampled high
    always_comb begin
        bus.req_ready = '0;
        transfer      = !rst && grant_any;
        if (transfer) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    assign xfer_addr = bus.req_addr[grant_idx];
    assign xfer_data = bus.req_data[grant_idx];

    // Scoreboard next state: writeback clears, claim sets (claim wins on collision)
    always_comb begin
        pending_d = pending_q;
        if (transfer) begin
            pending_d[xfer_addr] = 1'b0;
        end
        if (bus.claim_valid) begin
            pending_d[bus.claim_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Pointer, registered write port and scoreboard state
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= PTR_W'(REQUESTERS - 1);
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
            if (transfer) begin
                last_q    <= grant_idx;
                // Writes to register 0 are accepted but never reach the file
                wr_en_q   <= (xfer_addr != '0);
                wr_addr_q <= xfer_addr;
                wr_data_q <= xfer_data;
            end else begin
                wr_en_q <= 1'b0;
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.pending = pending_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: the driver predicts grants, writes and the
// pending vector from a queue-level model and pushes them; a negedge monitor
// pops and compares against the DUT.
module tb_wb_arbiter;
    localparam int R = 3;
    localparam int C = 32;

    typedef struct {
        logic [R-1:0] ready;
        bit           wen;
        logic [4:0]   addr;
        logic [31:0]  data;
        logic [C-1:0] pend;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    exp_t exp_q[$];

    // Reference model state
    int           m_last;
    logic [C-1:0] m_pend;

    // Requester state: a request is held until the model says it was granted
    bit          act[R];
    logic [4:0]  a_addr[R];
    logic [31:0] a_data[R];
    bit          rearm[R];
    bit          gen_rand;

    wb_arbiter_if #(.REQUESTERS(R), .COUNT(C), .DATA_W(32)) bus ();

    wb_arbiter #(.REQUESTERS(R), .COUNT(C), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic new_req(input int i);
        act[i]    = 1'b1;
        a_addr[i] = 5'($urandom_range(0, 31));
        a_data[i] = $urandom;
    endtask

    task automatic set_req(input int i, input logic [4:0] addr, input logic [31:0] data);
        act[i]    = 1'b1;
        a_addr[i] = addr;
        a_data[i] = data;
    endtask

    // Drive one cycle of inputs, predict its outcome, then advance to just past the edge
    task automatic step(input bit do_rst, input bit cv, input logic [4:0] ca);
        exp_t e;
        int   g;
        rst = do_rst;
        for (int i = 0; i < R; i++) begin
            bus.req_valid[i] = act[i];
            bus.req_addr[i]  = a_addr[i];
            bus.req_data[i]  = a_data[i];
        end
        bus.claim_valid = cv;
        bus.claim_addr  = ca;

        g = -1;
        if (!do_rst) begin
            for (int k = 1; k <= R; k++) begin
                int idx;
                idx = (m_last + k) % R;
                if (g < 0 && act[idx]) g = idx;
            end
        end

        e.ready = '0;
        e.wen   = 1'b0;
        e.addr  = '0;
        e.data  = '0;
        if (do_rst) begin
            m_pend = '0;
            m_last = R - 1;
        end else begin
            if (g >= 0) begin
                e.ready[g] = 1'b1;
                e.wen      = (a_addr[g] != 0);
                e.addr     = a_addr[g];
                e.data     = a_data[g];
                m_pend[a_addr[g]] = 1'b0;
                m_last     = g;
            end
            if (cv && ca != 0) m_pend[ca] = 1'b1;
        end
        e.pend = m_pend;
        exp_q.push_back(e);

        if (g >= 0) begin
            if (rearm[g]) new_req(g);
            else act[g] = 1'b0;
        end
        if (gen_rand) begin
            for (int i = 0; i < R; i++) begin
                if (!act[i] && $urandom_range(0, 2) == 0) new_req(i);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: ready is checked in the cycle it was predicted for, write port
    // and pending one cycle later
    initial begin
        exp_t prev;
        exp_t cur;
        bit   have;
        have = 1'b0;
        forever begin
            @(negedge clk);
            if (have) begin
                chk("wr_en", 64'(bus.wr_en), 64'(prev.wen));
                if (prev.wen) begin
                    chk("wr_addr", 64'(bus.wr_addr), 64'(prev.addr));
                    chk("wr_data", 64'(bus.wr_data), 64'(prev.data));
                end
                chk("pending", 64'(bus.pending), 64'(prev.pend));
            end
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                chk("req_ready", 64'(bus.req_ready), 64'(cur.ready));
                prev = cur;
                have = 1'b1;
            end else begin
                have = 1'b0;
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.req_valid   = '0;
        bus.req_addr    = '0;
        bus.req_data    = '0;
        bus.claim_valid = 1'b0;
        bus.claim_addr  = '0;
        gen_rand        = 1'b0;
        m_last          = R - 1;
        m_pend          = '0;
        for (int i = 0; i < R; i++) begin
            act[i]    = 1'b0;
            rearm[i]  = 1'b0;
            a_addr[i] = '0;
            a_data[i] = '0;
        end
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 5'd0);
        step(1'b1, 1'b0, 5'd0);

        // Three simultaneous requests drain in order 0,1,2
        set_req(0, 5'd5, 32'hA);
        set_req(1, 5'd6, 32'hB);
        set_req(2, 5'd7, 32'hC);
        repeat (5) step(1'b0, 1'b0, 5'd0);

        // Requesters 0 and 2 continuously valid alternate
        rearm[0] = 1'b1;
        rearm[2] = 1'b1;
        new_req(0);
        new_req(2);
        repeat (6) step(1'b0, 1'b0, 5'd0);
        rearm[0] = 1'b0;
        rearm[2] = 1'b0;
        repeat (3) step(1'b0, 1'b0, 5'd0);

        // Claim r9, then requester 1 writes it two cycles later
        step(1'b0, 1'b1, 5'd9);
        step(1'b0, 1'b0, 5'd0);
        set_req(1, 5'd9, 32'h1234);
        repeat (2) step(1'b0, 1'b0, 5'd0);

        // Claim and writeback to r4 in the same cycle
        set_req(0, 5'd4, 32'h4444);
        step(1'b0, 1'b1, 5'd4);
        step(1'b0, 1'b0, 5'd0);

        // Writeback to r0 and claim of r0
        set_req(2, 5'd0, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 5'd0);
        step(1'b0, 1'b0, 5'd0);

        // Reset mid-operation with a write in flight and r3 pending
        step(1'b0, 1'b1, 5'd3);
        set_req(1, 5'd12, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 5'd0);
        set_req(0, 5'd1, 32'h1);
        set_req(1, 5'd2, 32'h2);
        set_req(2, 5'd3, 32'h3);
        step(1'b1, 1'b1, 5'd7);
        repeat (4) step(1'b0, 1'b0, 5'd0);

        // Randomized traffic with claims and occasional resets
        gen_rand = 1'b1;
        repeat (400) begin
            bit r;
            r = ($urandom_range(0, 99) == 0);
            step(r, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)));
        end
        gen_rand = 1'b0;
        repeat (6) step(1'b0, 1'b0, 5'd0);

        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter REQUESTERS, default 3: number of writeback requesters (functional units) sharing one register-file write port.
REQ-002 Parameter COUNT, default 32: number of architectural registers tracked.
REQ-003 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port req_valid  input  [REQUESTERS] x 1  requester i holds a writeback.
REQ-006 Port req_ready  output  [REQUESTERS] x 1  requester i's writeback is accepted this cycle.
REQ-007 Port req_addr  input  [REQUESTERS] x reg_idx  destination register of requester i.
REQ-008 Port req_data  input  [REQUESTERS] x gpreg  result value of requester i.
REQ-009 Port wr_en  output  1  register-file write strobe.
REQ-010 Port wr_addr  output  reg_idx  register-file write address.
REQ-011 Port wr_data  output  gpreg  register-file write data.
REQ-012 Port claim_valid  input  1  issue stage reserves a destination register this cycle.
REQ-013 Port claim_addr  input  reg_idx  register being reserved.
REQ-014 Port pending  output  COUNT x 1  bit r set = register r awaits writeback.

Function
REQ-015 Transfer on requester i occurs in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-016 At most one req_ready bit is 1 per cycle; req_ready[i] is 0 whenever req_valid[i] is 0.
REQ-017 When any req_valid is 1, exactly one requester is granted (req_ready=1) in that same cycle; no idle cycle while requests wait.
REQ-018 Grant is round-robin: search starts at the index after the last granted requester, wrapping from REQUESTERS-1 to 0.
REQ-019 Last-granted pointer updates only on a transfer; unchanged in cycles with no request.
REQ-020 req_ready is combinational from req_valid and pointer; no combinational dependence on req_addr/req_data.
REQ-021 Requester shall hold req_valid, req_addr, req_data stable until transfer; arbiter does not re-check this.
REQ-022 Write latency 1 cycle: transfer in cycle t drives wr_en=1, wr_addr, wr_data from the granted requester in cycle t+1 (registered outputs).
REQ-023 Transfer with req_addr=0 is accepted (req_ready=1) but produces wr_en=0 in t+1.
REQ-024 Cycle with no transfer: wr_en=0 in the next cycle; wr_addr/wr_data hold previous values.
REQ-025 Throughput: one transfer per cycle sustained; a requester with continuous valid is granted at least once every REQUESTERS cycles.
REQ-026 claim_valid=1 with claim_addr=r, r != 0, sets pending[r] at next edge.
REQ-027 claim to register 0 has no effect; pending[0] is constant 0.
REQ-028 Transfer with req_addr=r clears pending[r] at the same edge that registers wr_*.
REQ-029 Claim and transfer on the same r in the same cycle: claim wins, pending[r]=1 afterwards.
REQ-030 Transfer to r with pending[r]=0 is legal: write proceeds, pending[r] stays 0.
REQ-031 pending is a registered output, no combinational path from inputs.

Reset
REQ-032 rst sampled at rising clk; while high, all req_ready=0 regardless of req_valid.
REQ-033 After reset: wr_en=0, wr_addr=0, wr_data=0, pending all 0, pointer such that requester 0 has highest priority.
REQ-034 Reset asserted mid-operation discards any in-flight write: wr_en=0 from the edge where rst sampled high, pending cleared at that edge, claims that cycle ignored.

Verification
REQ-035 Reset, then req_valid=3'b111 addrs 5/6/7 data 0xA/0xB/0xC held, each dropping after its transfer -> grants 0,1,2 in consecutive cycles; wr_* shows (5,0xA),(6,0xB),(7,0xC) one cycle later each, wr_en=1 three cycles, then 0.
REQ-036 Requesters 0 and 2 valid continuously for 6 cycles -> grants alternate 0,2,0,2,0,2; requester 1 never granted; wr_en=1 every cycle.
REQ-037 claim r=9; two cycles later requester 1 writes r=9 data 0x1234 -> pending[9]=1 after claim, 0 the edge after transfer; wr_addr=9, wr_data=0x1234.
REQ-038 Same cycle: claim r=4 and transfer to r=4 -> pending[4]=1 after edge, wr_en=1 wr_addr=4.
REQ-039 Transfer with req_addr=0 data 0xFFFF_FFFF -> req_ready=1, next cycle wr_en=0; claim r=0 -> pending unchanged.
REQ-040 pending[3]=1 and transfer in flight, rst pulsed one cycle -> wr_en=0, pending=0, req_ready all 0 during reset, requester 0 granted first afterwards.
